klein_sched: RTL
================

# klein_sched

Request scheduler in front of a single `klein_64` encryption core. It arbitrates N requesters round-robin and latches the winner's plaintext and key. It issues the one-cycle `start` pulse, waits for the core's `ready` edge, and returns the ciphertext tagged with the requester index. A watchdog aborts with an error flag if the core never completes.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8)
- `TIMEOUT`, 63, maximum cycles from `core_start` to `core_ready` rising edge before abort

Ports:
- `ck`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  N_REQ  per-requester request valid
- `req_inp`  in  64*N_REQ  plaintexts; requester i owns bits [64i +: 64]
- `req_key`  in  64*N_REQ  keys; same packing as `req_inp`
- `req_ready`  out  N_REQ  one-hot grant/accept
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  3  index of the requester being answered
- `rsp_data`  out  64  ciphertext; 0 when `rsp_err`=1
- `rsp_err`  out  1  timeout abort
- `core_start`  out  1  start pulse to the `klein_64` core
- `core_inp`  out  64  plaintext to the core
- `core_key`  out  64  key to the core
- `core_ready`  in  1  core done level
- `core_out`  in  64  core ciphertext

## Operation
- FSM states: IDLE, START, WAIT_LO, WAIT_HI, RESP.
- **IDLE**
  - If any `req_valid` is set: `req_ready[g]`=1 combinationally for the round-robin winner g.
  - On handshake: latch inp/key into `core_inp`/`core_key`, latch g into `rsp_id`, update the pointer to g, go to START.
- **START**: `core_start`=1 for exactly one cycle; clear the watchdog; go to WAIT_LO.
- **WAIT_LO**: wait for `core_ready`=0. The core may still hold `ready` from the previous operation. Then go to WAIT_HI.
- **WAIT_HI**: wait for `core_ready`=1. Then latch `core_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
- **Watchdog**
  - Counts every cycle in WAIT_LO and WAIT_HI.
  - On reaching `TIMEOUT`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
- **RESP**
  - `rsp_valid`=1; `rsp_id`, `rsp_data` and `rsp_err` are held stable.
  - When `rsp_ready`=1, go to IDLE.
- **Round-robin**
  - Search starts at pointer+1, modulo N_REQ.
  - Reset pointer = N_REQ-1, so requester 0 wins the first tie.
  - A requester cannot win twice in a row while another is requesting.
- **Stability**: `core_inp`/`core_key` stay constant from START until the next accept. `req_ready` is 0 in every state other than IDLE.
- **Reset**
  - Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `core_start`=0, `core_inp`=0, `core_key`=0, watchdog=0, pointer=N_REQ-1, state=IDLE.
  - Reset mid-operation drops the in-flight job and produces no response.
  - The next `core_start` occurs only after a fresh accept.
- A requester dropping `req_valid` without a handshake is legal; it is simply not granted.

## Timing
- Accept at cycle t → `core_start`=1 at t+1.
- Core `ready` rises at cycle c → `rsp_valid`=1 at c+1.
- Latency from accept to `rsp_valid` = core latency + 3 cycles minimum (START, plus one cycle each to register the low and high edges).
- `rsp_ready` high in the first RESP cycle → IDLE next cycle. A new accept is possible in that cycle, so there is one idle bubble per job.
- Timeout: `rsp_valid` asserts exactly `TIMEOUT`+1 cycles after `core_start`.
- Accept, `rsp_ready` and watchdog expiry are evaluated only in their own states and never collide.

## Structure
- Package `klein_sched_pkg`:
  - state enum
  - `BLK_W`=64, `KEY_W`=64, `ID_W`=3
  - watchdog width = clog2(TIMEOUT+1)
- Sub-module `rr_arbiter`:
  - Parameterised on N_REQ.
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant plus encoded index.
  - Pure combinational; the pointer register lives in `klein_sched`.
- Top test harness instantiates `klein_sched` + `klein_64`.

## Test plan
- **Single job**: requester 0 sends key FFFFFFFFFFFFFFFF, inp 0000000000000000 → one `core_start` pulse; response `rsp_id`=0, `rsp_data`=6456764E8602E154, `rsp_err`=0.
- **Contention, N_REQ=2**:
  - Requester 0 sends key 0000000000000000, inp 1234567890ABCDEF; requester 1 sends key 1234567890ABCDEF, inp FFFFFFFFFFFFFFFF; both valid in the same cycle.
  - Responses arrive in order id0 → 629F9D6DFF95800E, then id1 → 592356C4997176C8.
- **Back-pressure**: hold `rsp_ready`=0 for 10 cycles → `rsp_valid`, `rsp_data` and `rsp_id` stay constant; `req_ready` stays 0 throughout.
- **Fairness**: requesters 0 and 1 request continuously for 4 jobs → grant order 0,1,0,1.
- **Timeout**: stub core with `ready` tied 0 → `rsp_valid` at `core_start`+64 cycles, `rsp_err`=1, `rsp_data`=0.
- **Reset mid-job**: assert `rst` during WAIT_HI → all outputs at reset values next cycle; no `rsp_valid`; the next accepted job completes normally.

Source files
------------

// File: rtl/klein_sched_pkg.sv
// klein_sched_pkg: shared types and widths for the klein_64 request scheduler.
//   state_e   - scheduler FSM states
//   BLK_W     - plaintext / ciphertext width
//   KEY_W     - key width
//   ID_W      - requester index width (up to 8 requesters)
//   wd_width  - watchdog counter width able to hold the timeout value
package klein_sched_pkg;

    localparam int unsigned BLK_W = 64;
    localparam int unsigned KEY_W = 64;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StResp
    } state_e;

    function automatic int unsigned wd_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/klein_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req  - request vector
//   ptr  - index of the last winner; the search starts at ptr+1 (mod N_REQ)
//   en   - when low no grant is issued
//   gnt  - one-hot grant
//   idx  - encoded index of the granted requester (0 when nothing is granted)
module rr_arbiter
    import klein_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);

    logic found;

    // Walk the requesters in priority order ptr+1, ptr+2, ... ptr; first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (en && !found && req[i] && (((int'(ptr) + off) % int'(N_REQ)) == i)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/klein_sched.sv
// klein_sched: round-robin scheduler in front of a single klein_64 encryption core.
//   ck, rst              - clock, synchronous active-high reset
//   req_valid/req_ready  - per-requester handshake; req_ready is the one-hot grant in IDLE
//   req_inp, req_key     - packed plaintexts/keys, requester i owns bits [64i +: 64]
//   rsp_valid/rsp_ready  - response handshake
//   rsp_id, rsp_data     - answered requester index and ciphertext (0 on abort)
//   rsp_err              - set when the watchdog aborted the job
//   core_start           - one-cycle start pulse to the core
//   core_inp, core_key   - operands held stable for the core until the next accept
//   core_ready, core_out - core done level and ciphertext
module klein_sched
    import klein_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [BLK_W*N_REQ-1:0] req_inp,
    input  logic [KEY_W*N_REQ-1:0] req_key,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [BLK_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   core_start,
    output logic [BLK_W-1:0]       core_inp,
    output logic [KEY_W-1:0]       core_key,
    input  logic                   core_ready,
    input  logic [BLK_W-1:0]       core_out
);

    localparam int unsigned     WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    state_e           state;
    logic [ID_W-1:0]  ptr;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_inc;
    logic             wd_expire;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [BLK_W-1:0] sel_inp;
    logic [KEY_W-1:0] sel_key;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .en (state == StIdle),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    // Grant only exists in IDLE and only for a valid requester, so a grant is the handshake.
    assign req_ready = gnt;

    // Expiry fires on the cycle the count would reach TIMEOUT, so the response
    // lands exactly TIMEOUT+1 cycles after the start pulse.
    assign wd_inc    = wd + 1'b1;
    assign wd_expire = (wd_inc == WD_MAX);

    always_comb begin
        sel_inp = '0;
        sel_key = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) begin
                sel_inp = req_inp[BLK_W*i +: BLK_W];
                sel_key = req_key[KEY_W*i +: KEY_W];
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state      <= StIdle;
            ptr        <= PTR_RST;
            wd         <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            core_start <= 1'b0;
            core_inp   <= '0;
            core_key   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|gnt) begin
                        core_inp   <= sel_inp;
                        core_key   <= sel_key;
                        rsp_id     <= gnt_idx;
                        ptr        <= gnt_idx;
                        core_start <= 1'b1;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    core_start <= 1'b0;
                    wd         <= '0;
                    state      <= StWaitLo;
                end
                // The core may still hold ready from its previous job; wait for it to drop.
                StWaitLo: begin
                    wd <= wd_inc;
                    if (wd_expire) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else if (!core_ready) begin
                        state <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    wd <= wd_inc;
                    if (core_ready) begin
                        rsp_data  <= core_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else if (wd_expire) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
